// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: N-deep in-order pipeline register chain with per-stage valid,
// stall (hold stages 0..S, bubble into S+1) and flush (squash younger stages).
// Stage 0 is the youngest (fed from fetch); stage N-1 is the oldest (commit).
// Retire, bubble and squash counters are exported for performance debug.
module pipe_stage_ctrl #(
  parameter int unsigned    N      = 4,
  parameter int unsigned    W      = 32,
  parameter logic [W-1:0]   BUBBLE = W'(32'h0000_0013),
  parameter int unsigned    SW     = $clog2(N + 1),
  parameter int unsigned    CW     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  input  logic            stall_req,
  input  logic [SW-1:0]   stall_stage,
  input  logic            flush_req,
  input  logic [SW-1:0]   flush_stage,
  output logic [N-1:0]    stage_valid,
  output logic [N*W-1:0]  stage_data,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_fire,
  output logic [CW-1:0]   retire_cnt,
  output logic [CW-1:0]   bubble_cnt,
  output logic [CW-1:0]   kill_cnt
);

  // Pipeline state
  logic [N-1:0]  valid_q, valid_d;
  logic [W-1:0]  data_q [N];
  logic [W-1:0]  data_d [N];

  // Performance counters
  logic [CW-1:0] retire_q, bubble_q, kill_q;
  logic [CW-1:0] kill_add;
  logic          bubble_inc;

  // Decoded request controls
  logic          fl;
  logic          st;
  int unsigned   flush_lim;
  int unsigned   stall_lim;
  logic [N-1:0]  hold;

  // Decode flush/stall requests; a flush overrides any stall in the same cycle
  always_comb begin
    fl        = flush_req && (flush_stage != '0);
    st        = stall_req && !fl;
    flush_lim = (32'(flush_stage) > N) ? N : 32'(flush_stage);
    stall_lim = (32'(stall_stage) > N - 1) ? N - 1 : 32'(stall_stage);
  end

  // Per-stage hold mask: stages 0..S freeze while a stall is active
  always_comb begin
    hold = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hold[i] = st && (i <= stall_lim);
    end
  end

  // Next-state selection per stage: flush, hold, load/advance, bubble injection
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;

    // Stage 0: any active flush has F >= 1, so stage 0 is always squashed
    if (fl) begin
      valid_d[0] = 1'b0;
      data_d[0]  = BUBBLE;
    end else if (!hold[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_valid ? in_data : BUBBLE;
    end

    for (int unsigned i = 1; i < N; i++) begin
      if (fl && (i <= flush_lim)) begin
        // Stage F itself refills from the squashed stage F-1, hence i <= F
        valid_d[i] = 1'b0;
        data_d[i]  = BUBBLE;
      end else if (hold[i]) begin
        valid_d[i] = valid_q[i];
        data_d[i]  = data_q[i];
      end else if (hold[i-1]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = BUBBLE;
      end else begin
        valid_d[i] = valid_q[i-1];
        // Invalid stages always carry BUBBLE, which the source already holds
        data_d[i]  = data_q[i-1];
      end
    end
  end

  // Counter increments: squashed valid entries and stall-inserted bubbles
  always_comb begin
    kill_add   = '0;
    bubble_inc = 1'b0;
    if (fl) begin
      for (int unsigned i = 0; i < N; i++) begin
        if ((i < flush_lim) && valid_q[i]) begin
          kill_add = kill_add + CW'(1);
        end
      end
    end
    // Only count a bubble when it displaces a real instruction from stage S
    if (st) begin
      for (int unsigned i = 0; i < N - 1; i++) begin
        if ((i == stall_lim) && valid_q[i]) begin
          bubble_inc = 1'b1;
        end
      end
    end
  end

  // Oldest stage leaves unless it is held by a full stall or wiped by F = N
  always_comb begin
    out_fire = valid_q[N-1]
             & ~(st & (stall_lim == N - 1))
             & ~(fl & (flush_lim == N));
  end

  // Pipeline registers with synchronous reset to an empty pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        data_q[i] <= BUBBLE;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < N; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Performance counters, wrapping modulo 2^CW
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
      bubble_q <= '0;
      kill_q   <= '0;
    end else begin
      retire_q <= retire_q + CW'(out_fire);
      bubble_q <= bubble_q + CW'(bubble_inc);
      kill_q   <= kill_q + kill_add;
    end
  end

  // Flatten per-stage payloads onto the stage_data bus
  always_comb begin
    stage_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      stage_data[i*W +: W] = data_q[i];
    end
  end

  assign in_ready    = ~fl & ~hold[0];
  assign stage_valid = valid_q;
  assign out_valid   = valid_q[N-1];
  assign out_data    = data_q[N-1];
  assign retire_cnt  = retire_q;
  assign bubble_cnt  = bubble_q;
  assign kill_cnt    = kill_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl (N=4, W=32): reset, streaming, stalls,
// flushes and mid-stream reset, with hand-computed expected values.
module tb_pipe_stage_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 32;
  localparam logic [31:0] B  = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           stall_req;
  logic [SW-1:0]  stall_stage;
  logic           flush_req;
  logic [SW-1:0]  flush_stage;
  logic [N-1:0]   stage_valid;
  logic [N*W-1:0] stage_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_fire;
  logic [CW-1:0]  retire_cnt;
  logic [CW-1:0]  bubble_cnt;
  logic [CW-1:0]  kill_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_ctrl #(
    .N      (N),
    .W      (W),
    .BUBBLE (B),
    .SW     (SW),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stall_req   (stall_req),
    .stall_stage (stall_stage),
    .flush_req   (flush_req),
    .flush_stage (flush_stage),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_fire    (out_fire),
    .retire_cnt  (retire_cnt),
    .bubble_cnt  (bubble_cnt),
    .kill_cnt    (kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pk(input logic [31:0] s0, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic chk_state(input string tag, input logic [3:0] v, input logic [127:0] d,
                           input int r, input int bb, input int k);
    chk({tag, ".valid"},  128'(stage_valid), 128'(v));
    chk({tag, ".data"},   stage_data, d);
    chk({tag, ".retire"}, 128'(retire_cnt), 128'(r));
    chk({tag, ".bubble"}, 128'(bubble_cnt), 128'(bb));
    chk({tag, ".kill"},   128'(kill_cnt), 128'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]   ev;
    logic [127:0] ed;
    int           v;

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    stall_req = 1'b0; stall_stage = '0; flush_req = 1'b0; flush_stage = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk_state("reset", 4'b0000, pk(B, B, B, B), 0, 0, 0);
    chk("reset.in_ready", 128'(in_ready), 128'(1));
    chk("reset.out_valid", 128'(out_valid), 128'(0));

    // Streaming 1..8; entry j reaches stage 3 after edge j+3
    in_valid = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      in_data = 32'(j);
      #1;
      chk($sformatf("stream%0d.in_ready", j), 128'(in_ready), 128'(1));
      chk($sformatf("stream%0d.out_fire", j), 128'(out_fire), 128'(j >= 5));
      step();
      ev = '0;
      ed = '0;
      for (int k = 0; k < 4; k++) begin
        v = j - k;
        ev[k] = (v >= 1);
        ed[k*32 +: 32] = (v >= 1) ? 32'(v) : B;
      end
      chk($sformatf("stream%0d.valid", j), 128'(stage_valid), 128'(ev));
      chk($sformatf("stream%0d.data", j), stage_data, ed);
      chk($sformatf("stream%0d.out_valid", j), 128'(out_valid), 128'(j >= 4));
      chk($sformatf("stream%0d.retire", j), 128'(retire_cnt), 128'((j >= 4) ? j - 4 : 0));
    end
    chk("stream.out_data", 128'(out_data), 128'(5));

    // Stall S=1 one cycle: stages 8,7,6,5 -> 8,7,bubble,6; 5 retires
    in_data = 32'd9; stall_req = 1'b1; stall_stage = 3'd1;
    #1;
    chk("stall1.in_ready", 128'(in_ready), 128'(0));
    chk("stall1.out_fire", 128'(out_fire), 128'(1));
    step();
    chk_state("stall1", 4'b1011, pk(8, 7, B, 6), 5, 1, 0);
    stall_req = 1'b0;
    step();
    chk_state("stall1.after", 4'b0111, pk(9, 8, 7, B), 6, 1, 0);
    in_data = 32'd10;
    step();
    chk_state("refill", 4'b1111, pk(10, 9, 8, 7), 6, 1, 0);

    // Full stall two cycles (S=3, then S=7 clamps to 3)
    in_data = 32'd11; stall_req = 1'b1; stall_stage = 3'd3;
    #1;
    chk("stall3a.in_ready", 128'(in_ready), 128'(0));
    chk("stall3a.out_fire", 128'(out_fire), 128'(0));
    step();
    chk_state("stall3a", 4'b1111, pk(10, 9, 8, 7), 6, 1, 0);
    stall_stage = 3'd7;
    #1;
    chk("stall3b.out_fire", 128'(out_fire), 128'(0));
    step();
    chk_state("stall3b", 4'b1111, pk(10, 9, 8, 7), 6, 1, 0);
    stall_req = 1'b0;
    step();
    chk_state("resume1", 4'b1111, pk(11, 10, 9, 8), 7, 1, 0);
    in_data = 32'd12;
    step();
    chk_state("resume2", 4'b1111, pk(12, 11, 10, 9), 8, 1, 0);

    // Flush F=2 with stall S=1: stall ignored, 10 survives into stage 3
    in_data = 32'd13; flush_req = 1'b1; flush_stage = 3'd2;
    stall_req = 1'b1; stall_stage = 3'd1;
    #1;
    chk("flush2.in_ready", 128'(in_ready), 128'(0));
    chk("flush2.out_fire", 128'(out_fire), 128'(1));
    step();
    chk_state("flush2", 4'b1000, pk(B, B, B, 10), 9, 1, 2);
    flush_req = 1'b0; stall_req = 1'b0;
    step();
    chk_state("flush2.after", 4'b0001, pk(13, B, B, B), 10, 1, 2);
    for (int j = 14; j <= 16; j++) begin
      in_data = 32'(j);
      step();
    end
    chk_state("refill2", 4'b1111, pk(16, 15, 14, 13), 10, 1, 2);

    // Flush F=4 clears everything, oldest does not fire
    in_data = 32'd17; flush_req = 1'b1; flush_stage = 3'd4;
    #1;
    chk("flush4.out_fire", 128'(out_fire), 128'(0));
    chk("flush4.in_ready", 128'(in_ready), 128'(0));
    step();
    chk_state("flush4", 4'b0000, pk(B, B, B, B), 10, 1, 6);

    // flush_req with flush_stage=0 is no flush
    flush_stage = 3'd0;
    #1;
    chk("flush0.in_ready", 128'(in_ready), 128'(1));
    step();
    chk_state("flush0", 4'b0001, pk(17, B, B, B), 10, 1, 6);
    flush_req = 1'b0;
    for (int j = 18; j <= 20; j++) begin
      in_data = 32'(j);
      step();
    end
    chk_state("prereset", 4'b1111, pk(20, 19, 18, 17), 10, 1, 6);

    // Mid-stream reset wins over a concurrent stall
    rst = 1'b1; stall_req = 1'b1; stall_stage = 3'd3; in_data = 32'd21;
    step();
    rst = 1'b0; stall_req = 1'b0; in_valid = 1'b0;
    #1;
    chk_state("midreset", 4'b0000, pk(B, B, B, B), 0, 0, 0);
    chk("midreset.in_ready", 128'(in_ready), 128'(1));
    step();
    chk_state("idle", 4'b0000, pk(B, B, B, B), 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
